// File: rtl/program_loader_pkg.sv
// Shared types and constants for the serial program loader.
// State encoding, default sync byte and halfword index width.
package program_loader_pkg;

    localparam int unsigned MEM_HALFWORDS_DEF = 512;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int unsigned IDX_W = $clog2(MEM_HALFWORDS_DEF) + 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLEAR,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA_LO,
        S_DATA_HI,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERROR
    } loader_state_t;

endpackage

// File: rtl/program_loader_if.sv
// Program memory write/clear port driven by the loader.
// The loader owns these signals; program memory only listens.
interface program_loader_if;

    logic [31:0] pm_byte_address;
    logic [15:0] pm_write_data;
    logic        pm_write_enable;
    logic        pm_new_instruction_write_enable;
    logic        pm_clear_ram;

    modport master (
        output pm_byte_address,
        output pm_write_data,
        output pm_write_enable,
        output pm_new_instruction_write_enable,
        output pm_clear_ram
    );

    modport slave (
        input pm_byte_address,
        input pm_write_data,
        input pm_write_enable,
        input pm_new_instruction_write_enable,
        input pm_clear_ram
    );

endinterface

// File: rtl/program_loader.sv
// Frames a UART byte stream into halfword writes to program memory,
// verifies an XOR checksum and stalls the CPU for the whole session.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned MEM_HALFWORDS  = MEM_HALFWORDS_DEF,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    program_loader_if.master pm,
    output logic             cpu_hold,
    output logic             load_done,
    output logic             load_error,
    output logic [IDX_W-1:0] halfwords_written
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    loader_state_t    state_q, state_d;
    logic [7:0]       len_lo_q, len_lo_d;
    logic [15:0]      len_q, len_d;
    logic [7:0]       data_lo_q, data_lo_d;
    logic [7:0]       chk_q, chk_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [31:0]      addr_q, addr_d;
    logic [15:0]      wdata_q, wdata_d;
    logic             err_q, err_d;
    logic             we_q, clr_q, done_q, hold_q;
    logic             timed, expired;
    logic [15:0]      len_rx;

    assign len_rx = {rx_data, len_lo_q};

    always_comb begin
        state_d   = state_q;
        len_lo_d  = len_lo_q;
        len_d     = len_q;
        data_lo_d = data_lo_q;
        chk_d     = chk_q;
        idx_d     = idx_q;
        tmo_d     = '0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        timed     = state_q inside {S_LEN_LO, S_LEN_HI, S_DATA_LO,
                                    S_DATA_HI, S_WRITE, S_CHECK};
        expired   = 1'b0;

        if (timed && !rx_valid) begin
            tmo_d   = tmo_q + 1'b1;
            expired = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
        end

        unique case (state_q)
            S_IDLE: begin
                if (rx_valid && rx_data == SYNC_BYTE)
                    state_d = S_CLEAR;
            end
            S_CLEAR: begin
                state_d = rx_valid ? S_ERROR : S_LEN_LO;
            end
            S_LEN_LO: begin
                if (rx_valid) begin
                    len_lo_d = rx_data;
                    state_d  = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (rx_valid) begin
                    len_d = len_rx;
                    if (len_rx > 16'(MEM_HALFWORDS))
                        state_d = S_ERROR;
                    else if (len_rx == 16'd0)
                        state_d = S_CHECK;
                    else
                        state_d = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (rx_valid) begin
                    data_lo_d = rx_data;
                    chk_d     = chk_q ^ rx_data;
                    state_d   = S_DATA_HI;
                end
            end
            S_DATA_HI: begin
                if (rx_valid) begin
                    chk_d   = chk_q ^ rx_data;
                    wdata_d = {rx_data, data_lo_q};
                    addr_d  = 32'({idx_q, 1'b0});
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                idx_d = idx_q + 1'b1;
                if (rx_valid)
                    state_d = S_ERROR;
                else if (16'(idx_q) + 16'd1 == len_q)
                    state_d = S_CHECK;
                else
                    state_d = S_DATA_LO;
            end
            S_CHECK: begin
                if (rx_valid)
                    state_d = (rx_data == chk_q) ? S_DONE : S_ERROR;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERROR: begin
                if (rx_valid && rx_data == SYNC_BYTE)
                    state_d = S_CLEAR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (expired)
            state_d = S_ERROR;

        // A new session starts from a clean slate before any length byte
        if (state_d == S_CLEAR) begin
            idx_d = '0;
            chk_d = '0;
            err_d = 1'b0;
        end

        if (state_d == S_ERROR)
            err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            len_lo_q  <= '0;
            len_q     <= '0;
            data_lo_q <= '0;
            chk_q     <= '0;
            idx_q     <= '0;
            tmo_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            we_q      <= 1'b0;
            clr_q     <= 1'b0;
            done_q    <= 1'b0;
            hold_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_lo_q  <= len_lo_d;
            len_q     <= len_d;
            data_lo_q <= data_lo_d;
            chk_q     <= chk_d;
            idx_q     <= idx_d;
            tmo_q     <= tmo_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            we_q      <= (state_d == S_WRITE);
            // Wipe memory again on error entry so a partial image never runs
            clr_q     <= (state_d == S_CLEAR) ||
                         (state_d == S_ERROR && state_q != S_ERROR);
            done_q    <= (state_d == S_DONE);
            hold_q    <= (state_d != S_IDLE);
        end
    end

    assign pm.pm_byte_address                 = addr_q;
    assign pm.pm_write_data                   = wdata_q;
    assign pm.pm_write_enable                 = we_q;
    assign pm.pm_new_instruction_write_enable = we_q;
    assign pm.pm_clear_ram                    = clr_q;

    assign cpu_hold          = hold_q;
    assign load_done         = done_q;
    assign load_error        = err_q;
    assign halfwords_written = idx_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: frames, errors, timeout
// and mid-session reset, against hand-computed expectations.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       cpu_hold;
    logic       load_done;
    logic       load_error;
    logic [9:0] halfwords_written;

    program_loader_if pm_bus ();

    program_loader #(
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .rx_valid         (rx_valid),
        .rx_data          (rx_data),
        .pm               (pm_bus),
        .cpu_hold         (cpu_hold),
        .load_done        (load_done),
        .load_error       (load_error),
        .halfwords_written(halfwords_written)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int n_wr = 0;
    int n_clr = 0;
    int n_done = 0;
    logic [31:0] wr_addr [8];
    logic [15:0] wr_data [8];

    logic [7:0] f2 [10] = '{8'hA5, 8'h03, 8'h00, 8'h93, 8'h00,
                            8'h17, 8'h01, 8'h6F, 8'hF0, 8'h1A};
    logic [7:0] f6 [8]  = '{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12,
                            8'h78, 8'h56, 8'h08};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic reset_mon();
        n_wr   = 0;
        n_clr  = 0;
        n_done = 0;
    endtask

    always @(posedge clk) begin
        #1;
        if (pm_bus.pm_write_enable || pm_bus.pm_new_instruction_write_enable) begin
            check("niwe_eq_we", 32'(pm_bus.pm_new_instruction_write_enable),
                  32'(pm_bus.pm_write_enable));
            if (pm_bus.pm_write_enable) begin
                if (n_wr < 8) begin
                    wr_addr[n_wr] = pm_bus.pm_byte_address;
                    wr_data[n_wr] = pm_bus.pm_write_data;
                end
                n_wr++;
            end
        end
        if (pm_bus.pm_clear_ram) n_clr++;
        if (load_done) n_done++;
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_hold", 32'(cpu_hold), 0);
        check("rst_err", 32'(load_error), 0);
        check("rst_done", 32'(load_done), 0);
        check("rst_we", 32'(pm_bus.pm_write_enable), 0);
        check("rst_clr", 32'(pm_bus.pm_clear_ram), 0);
        check("rst_addr", pm_bus.pm_byte_address, 0);
        check("rst_data", 32'(pm_bus.pm_write_data), 0);
        check("rst_hw", 32'(halfwords_written), 0);
        reset = 1'b0;
        reset_mon();

        send(8'hA5);
        check("t1_clr", 32'(pm_bus.pm_clear_ram), 1);
        check("t1_hold_start", 32'(cpu_hold), 1);
        send(8'h01);
        send(8'h00);
        send(8'h13);
        check("t1_no_early_we", 32'(pm_bus.pm_write_enable), 0);
        send(8'h00);
        check("t1_we", 32'(pm_bus.pm_write_enable), 1);
        check("t1_addr", pm_bus.pm_byte_address, 32'h0);
        check("t1_data", 32'(pm_bus.pm_write_data), 32'h0013);
        send(8'h13);
        check("t1_done", 32'(load_done), 1);
        check("t1_hold_done", 32'(cpu_hold), 1);
        @(negedge clk);
        check("t1_hold_idle", 32'(cpu_hold), 0);
        check("t1_done_pulse", 32'(load_done), 0);
        check("t1_nwr", 32'(n_wr), 1);
        check("t1_ndone", 32'(n_done), 1);
        check("t1_nclr", 32'(n_clr), 1);
        check("t1_hw", 32'(halfwords_written), 1);

        reset_mon();
        foreach (f2[i]) send(f2[i]);
        check("t2_done", 32'(load_done), 1);
        check("t2_err", 32'(load_error), 0);
        check("t2_nwr", 32'(n_wr), 3);
        check("t2_a0", wr_addr[0], 32'h0);
        check("t2_d0", 32'(wr_data[0]), 32'h0093);
        check("t2_a1", wr_addr[1], 32'h2);
        check("t2_d1", 32'(wr_data[1]), 32'h0117);
        check("t2_a2", wr_addr[2], 32'h4);
        check("t2_d2", 32'(wr_data[2]), 32'hF06F);
        check("t2_hw", 32'(halfwords_written), 3);

        reset_mon();
        send(8'hA5);
        send(8'h01);
        send(8'h00);
        send(8'h13);
        send(8'h00);
        send(8'h00);
        check("t3_err", 32'(load_error), 1);
        check("t3_clr_entry", 32'(pm_bus.pm_clear_ram), 1);
        check("t3_hold", 32'(cpu_hold), 1);
        @(negedge clk);
        check("t3_clr_once", 32'(pm_bus.pm_clear_ram), 0);
        check("t3_err_sticky", 32'(load_error), 1);
        check("t3_hold_stays", 32'(cpu_hold), 1);
        check("t3_nclr", 32'(n_clr), 2);
        check("t3_ndone", 32'(n_done), 0);
        reset_mon();
        send(8'hA5);
        check("t3_err_cleared", 32'(load_error), 0);
        check("t3_reclr", 32'(pm_bus.pm_clear_ram), 1);

        send(8'h01);
        send(8'h02);
        check("t4_err", 32'(load_error), 1);
        check("t4_hold", 32'(cpu_hold), 1);
        check("t4_nwr", 32'(n_wr), 0);
        check("t4_hw", 32'(halfwords_written), 0);

        reset_mon();
        send(8'hA5);
        send(8'h00);
        send(8'h00);
        send(8'h00);
        check("t5_done", 32'(load_done), 1);
        @(negedge clk);
        check("t5_nwr", 32'(n_wr), 0);
        check("t5_hold", 32'(cpu_hold), 0);
        send(8'hA5);
        send(8'h00);
        send(8'h00);
        repeat (99) @(negedge clk);
        check("t5_tmo_early", 32'(load_error), 0);
        @(negedge clk);
        check("t5_tmo_err", 32'(load_error), 1);
        check("t5_tmo_hold", 32'(cpu_hold), 1);

        send(8'hA5);
        send(8'h01);
        send(8'h00);
        send(8'h13);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t6_hold", 32'(cpu_hold), 0);
        check("t6_err", 32'(load_error), 0);
        check("t6_clr", 32'(pm_bus.pm_clear_ram), 0);
        check("t6_data", 32'(pm_bus.pm_write_data), 0);
        check("t6_hw", 32'(halfwords_written), 0);
        reset = 1'b0;
        reset_mon();
        foreach (f6[i]) send(f6[i]);
        check("t6_done", 32'(load_done), 1);
        check("t6_nwr", 32'(n_wr), 2);
        check("t6_a0", wr_addr[0], 32'h0);
        check("t6_d0", 32'(wr_data[0]), 32'h1234);
        check("t6_a1", wr_addr[1], 32'h2);
        check("t6_d1", 32'(wr_data[1]), 32'h5678);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Controller that sequences program memory over a byte stream from the UART receiver. It frames a load session, clears the memory's valid bits, assembles little-endian halfwords, and issues write strobes at consecutive halfword addresses. It verifies a checksum and holds the CPU in stall for the whole session. It sits between the UART RX block and program memory, and drives program memory's write/clear inputs exclusively.

## Interface
- MEM_HALFWORDS, 512: program memory capacity in 16-bit halfwords; maximum accepted length.
- SYNC_BYTE, 8'hA5: byte that opens a load session.
- TIMEOUT_CYCLES, 1_000_000: idle cycles between bytes before a session aborts.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe: rx_data holds a new byte.
- rx_data  in  8  received byte.
- pm_byte_address  out  32  halfword write address ×2; bit 0 always 0.
- pm_write_data  out  16  halfword to write.
- pm_write_enable  out  1  write strobe.
- pm_new_instruction_write_enable  out  1  always equal to pm_write_enable.
- pm_clear_ram  out  1  one-cycle pulse that invalidates all memory entries.
- cpu_hold  out  1  CPU stall; high for the whole session.
- load_done  out  1  one-cycle pulse on successful completion.
- load_error  out  1  sticky error flag; cleared by the next SYNC_BYTE.
- halfwords_written  out  10  count of halfwords written in the current/last session.

## Operation
- **Frame format:** SYNC_BYTE, LEN_LO, LEN_HI, then LEN halfwords sent low byte first, then CHK. LEN is a 16-bit halfword count. CHK is the XOR of all data bytes.
- **States:**
  - IDLE, CLEAR, LEN_LO, LEN_HI, DATA_LO, DATA_HI, WRITE, CHECK, DONE, ERROR.
- **Transitions:**
  - IDLE: a rx byte == SYNC_BYTE goes to CLEAR; all other bytes are ignored.
  - CLEAR: one cycle. pm_clear_ram=1, index/checksum/halfwords_written zeroed, load_error cleared. Then go to LEN_LO.
  - LEN_LO: the byte latches LEN[7:0]. LEN_HI: the byte latches LEN[15:8].
    - LEN > MEM_HALFWORDS goes to ERROR.
    - LEN==0 goes to CHECK.
    - Otherwise go to DATA_LO.
  - DATA_LO: the byte latches into data[7:0]. DATA_HI: the byte latches into data[15:8]. Every data byte is XORed into the checksum.
  - WRITE: one cycle.
    - Strobes pm_write_enable with pm_byte_address = {index,1'b0}.
    - Increments index and halfwords_written.
    - Goes to CHECK when index+1 == LEN, else to DATA_LO.
  - CHECK: a byte equal to the running checksum goes to DONE; any other value goes to ERROR.
  - DONE: one cycle. load_done=1, then IDLE.
  - ERROR:
    - load_error=1 and cpu_hold stays 1.
    - pm_clear_ram pulses on the entry cycle only, so a partial image never executes.
    - A SYNC_BYTE goes to CLEAR.
- **cpu_hold:** 1 in every state except IDLE. In DONE it is 1, and it drops on the IDLE cycle.
- **Overrun:** rx_valid in CLEAR or WRITE goes to ERROR.
- **Timeout:**
  - The counter resets on every rx_valid.
  - It counts only in LEN_LO..CHECK.
  - Reaching TIMEOUT_CYCLES goes to ERROR.
- **Outputs outside WRITE:** pm_write_enable=0 and pm_byte_address holds its last value.

## Timing
- Reset: state IDLE.
  - All strobes 0: pm_write_enable, pm_new_instruction_write_enable, pm_clear_ram, load_done.
  - cpu_hold=0, load_error=0, halfwords_written=0, pm_byte_address=0, pm_write_data=0.
- All outputs are registered.
- pm_clear_ram is high exactly one cycle after the SYNC_BYTE rx_valid cycle.
- A write strobe is high exactly one cycle after the DATA_HI rx_valid cycle. Address and data are stable in that same cycle.
- load_done is high one cycle after the CHK rx_valid cycle.
- Minimum rx_valid spacing is 2 cycles; a UART at any practical baud rate always satisfies this.
- Reset mid-session: reset returns to IDLE with cpu_hold=0. Memory contents are not restored, so a partially loaded image runs.
- A SYNC_BYTE inside a frame is treated as ordinary data, not as a restart.

## Structure
- program_loader_pkg holds:
  - the loader_state_t enum,
  - the default SYNC_BYTE value,
  - the address width constant (log2 of MEM_HALFWORDS, plus 1).
- There is no sub-module. The timeout counter and the FSM live in one always_ff plus one always_comb.

## Test plan
- **Single halfword:** A5,01,00,13,00,13 → one write at address 0x0 with data 0x0013, then load_done. cpu_hold high from the cycle after A5 until the cycle after done.
- **Three halfwords:** A5,03,00 then 93,00,17,01,6F,F0, with CHK = XOR of the six data bytes → writes at addresses 0x0, 0x2, 0x4 with data 0x0093, 0x0117, 0xF06F. halfwords_written=3.
- **Bad checksum:** as single halfword but CHK=0x00 → load_error=1, a second pm_clear_ram pulse, cpu_hold stays 1. Then a new A5 → load_error=0.
- **Length too large:** A5,01,02 (LEN=513) → ERROR with zero writes.
- **LEN=0:** A5,00,00,00 → load_done, no writes. Under the same stimulus, stopping after LEN_HI with TIMEOUT_CYCLES=100 → ERROR after 100 idle cycles.
- **Reset mid-frame:** reset asserted after the first data byte → all outputs at reset values on the next cycle. A following full frame loads correctly.
